// File: rtl/quad_warp_writer.sv
// Walks a captured warp coverage mask one pixel per cycle and writes each covered,
// on-screen pixel to the framebuffer write port, stalling on framebuffer backpressure.
module quad_warp_writer #(
    parameter int unsigned WARP_WIDTH = 240,
    parameter int unsigned COLOR_W    = 12,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WARP_WIDTH-1:0] isInside,
    input  logic [9:0]            warp_x,
    input  logic [9:0]            drawY,
    input  logic [COLOR_W-1:0]    color,
    output logic                  fb_we,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [COLOR_W-1:0]    fb_data,
    input  logic                  fb_ready,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned IdxW = (WARP_WIDTH > 1) ? $clog2(WARP_WIDTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [WARP_WIDTH-1:0] mask_q, mask_d;
    logic [9:0]            warp_x_q, warp_x_d;
    logic [9:0]            draw_y_q, draw_y_d;
    logic [COLOR_W-1:0]    color_q, color_d;

    logic [10:0] col;
    logic        pix;
    logic        accept;
    logic        advance;

    // Column is kept 11 bits wide so warps running past the right edge never wrap.
    always_comb begin
        col     = {1'b0, warp_x_q} + 11'(idx_q);
        pix     = (state_q == StScan) && mask_q[idx_q] && (32'(col) < SCREEN_W);
        accept  = in_valid && (state_q == StIdle);
        advance = !pix || fb_ready;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        warp_x_d = warp_x_q;
        draw_y_d = draw_y_q;
        color_d  = color_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    mask_d   = isInside;
                    warp_x_d = warp_x;
                    draw_y_d = drawY;
                    color_d  = color;
                    idx_d    = '0;
                    if ((isInside == '0) || (32'(drawY) >= SCREEN_H)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (advance) begin
                    if (idx_q == IdxW'(WARP_WIDTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            mask_q   <= '0;
            warp_x_q <= '0;
            draw_y_q <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            warp_x_q <= warp_x_d;
            draw_y_q <= draw_y_d;
            color_q  <= color_d;
        end
    end

    // Address and data come straight from registers, so they hold while a write stalls.
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q == StScan) || (state_q == StDone);
        done     = (state_q == StDone);
        fb_we    = pix;
        fb_addr  = ADDR_W'(32'(draw_y_q) * SCREEN_W + 32'(col));
        fb_data  = color_q;
    end

endmodule

// File: tb/tb_quad_warp_writer.sv
// Self-checking bench for quad_warp_writer: directed cases plus randomized warps
// compared against a per-warp expected write list.
module tb_quad_warp_writer;

    localparam int W      = 240;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  isInside;
    logic [9:0]    warp_x;
    logic [9:0]    drawY;
    logic [11:0]   color;
    logic          fb_we;
    logic [18:0]   fb_addr;
    logic [11:0]   fb_data;
    logic          fb_ready;
    logic          done;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    quad_warp_writer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .isInside (isInside),
        .warp_x   (warp_x),
        .drawY    (drawY),
        .color    (color),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready),
        .done     (done),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_mask(input int density_pct);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = ($urandom_range(0, 99) < density_pct);
        return m;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Offer one warp, then follow it to retirement. exp_done < 0 means "derive it".
    task automatic run_warp(input logic [W-1:0] m, input logic [9:0] wx, input logic [9:0] dy,
                            input logic [11:0] c, input int stall_pct, input int first_stall,
                            input int exp_done);
        int  q[$];
        int  stalls;
        int  stall_left;
        int  done_cyc;
        bit  empty;
        empty = (m == '0) || (int'(dy) >= SCR_H);
        if (!empty) begin
            for (int i = 0; i < W; i++) begin
                if (m[i] && (int'(wx) + i < SCR_W)) q.push_back(int'(dy) * SCR_W + int'(wx) + i);
            end
        end

        for (int k = 0; k < 8 && !in_ready; k++) step();
        check_eq("in_ready_at_offer", in_ready, 1);
        in_valid = 1'b1;
        isInside = m;
        warp_x   = wx;
        drawY    = dy;
        color    = c;
        step();

        stalls     = 0;
        stall_left = first_stall;
        done_cyc   = -1;
        for (int cyc = 1; cyc <= 3 * W; cyc++) begin
            // Stray descriptors while busy must never be taken.
            in_valid = 1'($urandom_range(0, 1));
            isInside = rand_mask(50);
            warp_x   = 10'($urandom);
            drawY    = 10'($urandom);
            color    = 12'($urandom);
            if (done) begin
                done_cyc = cyc;
                check_eq("done_no_write", fb_we, 0);
                check_eq("done_in_ready", in_ready, 0);
                check_eq("done_busy", busy, 1);
                break;
            end
            check_eq("scan_in_ready", in_ready, 0);
            check_eq("scan_busy", busy, 1);
            fb_ready = ($urandom_range(0, 99) >= stall_pct);
            if (fb_we) begin
                if (stall_left > 0) begin
                    fb_ready = 1'b0;
                    stall_left--;
                end
                if (q.size() == 0) begin
                    check_eq("extra_write", fb_we, 0);
                end else begin
                    check_eq("fb_addr", 32'(fb_addr), q[0]);
                    check_eq("fb_data", 32'(fb_data), 32'(c));
                    if (fb_ready) void'(q.pop_front());
                    else stalls++;
                end
            end
            step();
        end
        in_valid = 1'b0;
        fb_ready = 1'b1;

        check_eq("done_cycle", done_cyc, empty ? 1 : W + 1 + stalls);
        if (exp_done >= 0) check_eq("done_cycle_fixed", done_cyc, exp_done);
        check_eq("writes_missing", q.size(), 0);
        step();
        check_eq("idle_in_ready", in_ready, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
    endtask

    initial begin
        logic [W-1:0] m;
        Reset    = 1'b1;
        in_valid = 1'b0;
        isInside = '0;
        warp_x   = '0;
        drawY    = '0;
        color    = '0;
        fb_ready = 1'b1;
        step();
        step();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_fb_we", fb_we, 0);
        check_eq("rst_fb_addr", 32'(fb_addr), 0);
        check_eq("rst_fb_data", 32'(fb_data), 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        Reset = 1'b0;
        step();

        // Full row start, sparse mask, right-edge clipping, stalled single write.
        run_warp({W{1'b1}}, 10'd0, 10'd0, 12'hF00, 0, 0, 241);
        m = '0;
        m[0] = 1'b1; m[5] = 1'b1; m[239] = 1'b1;
        run_warp(m, 10'd100, 10'd2, 12'h0A5, 0, 0, 241);
        run_warp({W{1'b1}}, 10'd500, 10'd10, 12'h123, 0, 0, 241);
        m = '0;
        m[3] = 1'b1;
        run_warp(m, 10'd0, 10'd0, 12'h777, 0, 4, 245);
        run_warp('0, 10'd20, 10'd30, 12'hABC, 0, 0, 1);
        run_warp({W{1'b1}}, 10'd20, 10'd480, 12'hABC, 0, 0, 1);

        // Reset in the middle of a full-mask warp.
        for (int k = 0; k < 8 && !in_ready; k++) step();
        in_valid = 1'b1;
        isInside = {W{1'b1}};
        warp_x   = 10'd0;
        drawY    = 10'd5;
        color    = 12'hFFF;
        step();
        in_valid = 1'b0;
        for (int cyc = 1; cyc < 51; cyc++) step();
        check_eq("pre_reset_addr", 32'(fb_addr), 5 * SCR_W + 50);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("mid_rst_fb_we", fb_we, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_busy", busy, 0);
        step();
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_fb_we", fb_we, 0);
        m = '0;
        m[0] = 1'b1; m[1] = 1'b1;
        run_warp(m, 10'd7, 10'd1, 12'h05A, 0, 0, 241);

        // Randomized warps: mixed density, position, off-screen rows and backpressure.
        for (int t = 0; t < 24; t++) begin
            int dens;
            int sp;
            dens = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100));
            sp   = int'($urandom_range(0, 40));
            run_warp(rand_mask(dens), 10'($urandom), 10'($urandom_range(0, 520)),
                     12'($urandom), sp, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
